// File: rtl/ariane_pkg.sv
// Shared core constants used by the divider front-end.
package ariane_pkg;
    localparam int unsigned TRANS_ID_BITS = 3;
endpackage

// File: rtl/div_frontend.sv
// Issue/writeback front-end wrapped around a serial divider.
// Optional: DIV_FRONTEND_ZERO_SHORTCUT_EN bypasses the divider on a zero divisor.
module div_frontend #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic                                 req_vld_i,
    output logic                                 req_rdy_o,
    input  logic [ariane_pkg::TRANS_ID_BITS-1:0] id_i,
    input  logic [WIDTH-1:0]                     op_a_i,
    input  logic [WIDTH-1:0]                     op_b_i,
    input  logic [1:0]                           opcode_i,
    input  logic                                 word_i,
    output logic                                 div_vld_o,
    input  logic                                 div_rdy_i,
    output logic [ariane_pkg::TRANS_ID_BITS-1:0] div_id_o,
    output logic [WIDTH-1:0]                     div_op_a_o,
    output logic [WIDTH-1:0]                     div_op_b_o,
    output logic [1:0]                           div_opcode_o,
    output logic                                 div_flush_o,
    input  logic                                 div_out_vld_i,
    output logic                                 div_out_rdy_o,
    input  logic [ariane_pkg::TRANS_ID_BITS-1:0] div_id_i,
    input  logic [WIDTH-1:0]                     div_res_i,
    output logic                                 wb_vld_o,
    input  logic                                 wb_rdy_i,
    output logic [ariane_pkg::TRANS_ID_BITS-1:0] wb_id_o,
    output logic [WIDTH-1:0]                     wb_res_o
);

    localparam int unsigned IW = ariane_pkg::TRANS_ID_BITS;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_e;

    state_e           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [1:0]       opcode;
    logic             word;
    logic [IW-1:0]    id;
    logic             div_rdy_q;
    logic             active;
    logic [WIDTH-1:0] adj_a;
    logic [WIDTH-1:0] adj_b;

    function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] v,
                                               input logic sgn);
        return {{(WIDTH-32){sgn & v[31]}}, v[31:0]};
    endfunction

    always_comb begin
        adj_a = word_i ? ext32(op_a_i, opcode_i[0]) : op_a_i;
        adj_b = word_i ? ext32(op_b_i, opcode_i[0]) : op_b_i;
    end

`ifdef DIV_FRONTEND_ZERO_SHORTCUT_EN
    logic [WIDTH-1:0] zero_res;

    // Divide-by-zero results follow the RISC-V rules without the divider.
    always_comb begin
        zero_res = '1;
        if (opcode_i[1]) begin
            zero_res = word_i ? ext32(adj_a, 1'b1) : adj_a;
        end
    end
`endif

    // Handshake outputs are killed by flush and held low through reset.
    assign active        = rst_ni & ~flush_i;
    assign req_rdy_o     = active & (state == IDLE);
    assign div_vld_o     = active & (state == ISSUE) & div_rdy_q;
    assign div_out_rdy_o = active & (state == WAIT);
    assign wb_vld_o      = active & (state == RESULT);
    assign div_flush_o   = flush_i;

    assign div_op_a_o   = op_a;
    assign div_op_b_o   = op_b;
    assign div_opcode_o = opcode;
    assign div_id_o     = id;
    assign wb_res_o     = res;
    assign wb_id_o      = id;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            opcode    <= '0;
            word      <= 1'b0;
            id        <= '0;
            div_rdy_q <= 1'b0;
        end else begin
            div_rdy_q <= div_rdy_i;
            if (flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_vld_i) begin
                            op_a   <= adj_a;
                            op_b   <= adj_b;
                            opcode <= opcode_i;
                            word   <= word_i;
                            id     <= id_i;
                            state  <= ISSUE;
`ifdef DIV_FRONTEND_ZERO_SHORTCUT_EN
                            if (adj_b == '0) begin
                                res   <= zero_res;
                                state <= RESULT;
                            end
`endif
                        end
                    end
                    ISSUE: begin
                        if (div_rdy_q) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (div_out_vld_i) begin
                            res   <= word ? ext32(div_res_i, 1'b1) : div_res_i;
                            state <= RESULT;
                        end
                    end
                    RESULT: begin
                        if (wb_rdy_i) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    id_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        div_out_vld_i && div_out_rdy_o |-> div_id_i == id);
`endif

endmodule

// File: tb/tb_div_frontend.sv
// Self-checking bench for div_frontend: vector table, corner sequences
// and randomized operations against a behavioural division model.
module tb_div_frontend;
    import ariane_pkg::*;

    localparam int W  = 64;
    localparam int IW = TRANS_ID_BITS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          req_vld;
    logic          req_rdy;
    logic [IW-1:0] id;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [1:0]    opcode;
    logic          word;
    logic          div_vld;
    logic          div_rdy;
    logic [IW-1:0] div_id_out;
    logic [W-1:0]  div_op_a;
    logic [W-1:0]  div_op_b;
    logic [1:0]    div_opcode;
    logic          div_flush;
    logic          div_out_vld;
    logic          div_out_rdy;
    logic [IW-1:0] div_id_in;
    logic [W-1:0]  div_res;
    logic          wb_vld;
    logic          wb_rdy;
    logic [IW-1:0] wb_id;
    logic [W-1:0]  wb_res;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_frontend #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_vld_i(req_vld), .req_rdy_o(req_rdy), .id_i(id),
        .op_a_i(op_a), .op_b_i(op_b), .opcode_i(opcode), .word_i(word),
        .div_vld_o(div_vld), .div_rdy_i(div_rdy), .div_id_o(div_id_out),
        .div_op_a_o(div_op_a), .div_op_b_o(div_op_b),
        .div_opcode_o(div_opcode), .div_flush_o(div_flush),
        .div_out_vld_i(div_out_vld), .div_out_rdy_o(div_out_rdy),
        .div_id_i(div_id_in), .div_res_i(div_res),
        .wb_vld_o(wb_vld), .wb_rdy_i(wb_rdy), .wb_id_o(wb_id),
        .wb_res_o(wb_res)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  a, b;
        logic [1:0]    opc;
        logic          word;
        logic [W-1:0]  exp_a, exp_b, ret, exp_wb;
        int            lat, stall, hold;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sext32(input logic [W-1:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [W-1:0] adj(input logic [W-1:0] v,
                                         input logic [1:0] opc,
                                         input logic wd);
        if (!wd) return v;
        return opc[0] ? sext32(v) : {32'h0, v[31:0]};
    endfunction

    // Raw divider output per RISC-V rules; word results carry junk above bit 31.
    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [1:0] opc,
                                             input logic wd);
        logic [31:0] q32, r32;
        logic [W-1:0] q, r;
        int sa, sb;
        longint la, lb;
        if (wd) begin
            sa = a[31:0];
            sb = b[31:0];
            if (b[31:0] == 32'h0) begin
                q32 = '1;
                r32 = a[31:0];
            end else if (opc[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1) begin
                q32 = 32'h8000_0000;
                r32 = 32'h0;
            end else if (opc[0]) begin
                q32 = sa / sb;
                r32 = sa % sb;
            end else begin
                q32 = a[31:0] / b[31:0];
                r32 = a[31:0] % b[31:0];
            end
            return {32'hDEAD_BEEF, opc[1] ? r32 : q32};
        end
        la = a;
        lb = b;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (opc[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else if (opc[0]) begin
            q = la / lb;
            r = la % lb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return opc[1] ? r : q;
    endfunction

    function automatic vec_t mkv(input logic [IW-1:0] i, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [1:0] opc,
                                 input logic wd, input logic [W-1:0] ea,
                                 input logic [W-1:0] eb, input logic [W-1:0] ret,
                                 input logic [W-1:0] ewb, input int lat,
                                 input int stall, input int hold);
        vec_t v;
        v.id = i; v.a = a; v.b = b; v.opc = opc; v.word = wd;
        v.exp_a = ea; v.exp_b = eb; v.ret = ret; v.exp_wb = ewb;
        v.lat = lat; v.stall = stall; v.hold = hold;
        return v;
    endfunction

    function automatic vec_t mk_random();
        vec_t v;
        v.id   = IW'($urandom);
        v.opc  = 2'($urandom);
        v.word = 1'($urandom);
        v.a    = {$urandom, $urandom};
        if ($urandom_range(0, 5) == 0) v.a = 64'h8000_0000_0000_0000;
        case ($urandom_range(0, 5))
            0:       v.b = '0;
            1:       v.b = {$urandom, 32'h0};
            2:       v.b = '1;
            3:       v.b = 64'($urandom_range(1, 9));
            default: v.b = {$urandom, $urandom};
        endcase
        v.exp_a  = adj(v.a, v.opc, v.word);
        v.exp_b  = adj(v.b, v.opc, v.word);
        v.ret    = ref_div(v.exp_a, v.exp_b, v.opc, v.word);
        v.exp_wb = v.word ? sext32(v.ret) : v.ret;
`ifdef DIV_FRONTEND_ZERO_SHORTCUT_EN
        if (v.exp_b == '0)
            v.exp_wb = v.opc[1] ? (v.word ? sext32(v.exp_a) : v.exp_a) : '1;
`endif
        v.lat   = $urandom_range(0, 3);
        v.stall = $urandom_range(0, 2);
        v.hold  = $urandom_range(0, 2);
        return v;
    endfunction

    task automatic issue_to_result(input vec_t v);
        int n;
        div_rdy = (v.hold == 0);
        id = v.id; op_a = v.a; op_b = v.b; opcode = v.opc; word = v.word;
        req_vld = 1'b1;
        #1;
        n = 0;
        while (!req_rdy && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_req_rdy", W'(req_rdy), 1);
        @(negedge clk);
        req_vld = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        id   = IW'($urandom);
        #1;
`ifdef DIV_FRONTEND_ZERO_SHORTCUT_EN
        if (v.exp_b == '0) begin
            chk("sc_div_vld", W'(div_vld), 0);
            chk("sc_wb_vld", W'(wb_vld), 1);
            chk("sc_wb_res", wb_res, v.exp_wb);
            chk("sc_wb_id", W'(wb_id), W'(v.id));
        end else
`endif
        begin
            for (int i = 0; i < v.hold; i++) begin
                chk("hold_div_vld", W'(div_vld), 0);
                chk("hold_op_a", div_op_a, v.exp_a);
                @(negedge clk); #1;
            end
            if (v.hold > 0) begin
                div_rdy = 1'b1;
                @(negedge clk); #1;
            end
            chk("issue_div_vld", W'(div_vld), 1);
            chk("issue_op_a", div_op_a, v.exp_a);
            chk("issue_op_b", div_op_b, v.exp_b);
            chk("issue_opcode", W'(div_opcode), W'(v.opc));
            chk("issue_id", W'(div_id_out), W'(v.id));
            @(negedge clk); #1;
            chk("wait_div_vld", W'(div_vld), 0);
            chk("wait_out_rdy", W'(div_out_rdy), 1);
            repeat (v.lat) begin
                @(negedge clk); #1;
            end
            div_out_vld = 1'b1;
            div_id_in   = v.id;
            div_res     = v.ret;
            @(negedge clk);
            div_out_vld = 1'b0;
            div_res     = {$urandom, $urandom};
            #1;
            chk("res_wb_vld", W'(wb_vld), 1);
            chk("res_wb_res", wb_res, v.exp_wb);
            chk("res_wb_id", W'(wb_id), W'(v.id));
        end
        repeat (v.stall) begin
            @(negedge clk); #1;
            chk("stall_wb_vld", W'(wb_vld), 1);
            chk("stall_wb_res", wb_res, v.exp_wb);
            chk("stall_wb_id", W'(wb_id), W'(v.id));
        end
    endtask

    task automatic finish_wb();
        wb_rdy = 1'b1;
        #1;
        chk("hs_req_rdy", W'(req_rdy), 0);
        @(negedge clk);
        wb_rdy = 1'b0;
        #1;
        chk("post_wb_vld", W'(wb_vld), 0);
        chk("post_req_rdy", W'(req_rdy), 1);
    endtask

    task automatic accept_only(input logic [IW-1:0] i);
        id = i; op_a = 64'd50; op_b = 64'd5; opcode = 2'd0; word = 1'b0;
        div_rdy = 1'b1;
        req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_vld = 1'b0; id = '0;
        op_a = '0; op_b = '0; opcode = '0; word = 1'b0;
        div_rdy = 1'b1; div_out_vld = 1'b0; div_id_in = '0;
        div_res = '0; wb_rdy = 1'b0;

        repeat (2) @(negedge clk);
        req_vld = 1'b1;
        #1;
        chk("rst_req_rdy", W'(req_rdy), 0);
        chk("rst_div_vld", W'(div_vld), 0);
        chk("rst_out_rdy", W'(div_out_rdy), 0);
        chk("rst_wb_vld", W'(wb_vld), 0);
        chk("rst_div_op_a", div_op_a, 0);
        chk("rst_div_op_b", div_op_b, 0);
        chk("rst_div_id", W'(div_id_out), 0);
        chk("rst_wb_res", wb_res, 0);
        chk("rst_wb_id", W'(wb_id), 0);
        req_vld = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_req_rdy", W'(req_rdy), 1);
        chk("idle_div_flush", W'(div_flush), 0);

        vecs.push_back(mkv(3, 64'd100, 64'd7, 2'd1, 1'b0, 64'd100, 64'd7,
                           64'd14, 64'd14, 0, 0, 0));
        vecs.push_back(mkv(5, 64'h0000_0000_8000_0000, '1, 2'd1, 1'b1,
                           64'hFFFF_FFFF_8000_0000, '1, 64'h0000_0000_8000_0000,
                           64'hFFFF_FFFF_8000_0000, 2, 1, 0));
        vecs.push_back(mkv(1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 2'd0, 1'b1,
                           64'h0000_0000_FFFF_FFF0, 64'd3, 64'h5555_5550,
                           64'h5555_5550, 1, 0, 0));
        vecs.push_back(mkv(6, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_0000_0007,
                           2'd2, 1'b1, 64'h0000_0000_9ABC_DEF0, 64'd7, 64'd6,
                           64'd6, 3, 2, 5));
        vecs.push_back(mkv(2, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 2'd3, 1'b0,
                           64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                           64'hFFFF_FFFF_FFFF_FFFE, 0, 3, 1));
        vecs.push_back(mkv(7, 64'h0000_0001_F000_0000, 64'h0000_0000_F000_0001,
                           2'd2, 1'b1, 64'h0000_0000_F000_0000,
                           64'h0000_0000_F000_0001, 64'h0000_0000_F000_0000,
                           64'hFFFF_FFFF_F000_0000, 0, 0, 2));
        vecs.push_back(mkv(4, '1, 64'd2, 2'd0, 1'b0, '1, 64'd2,
                           64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                           1, 1, 0));
        vecs.push_back(mkv(0, 64'h0000_0000_FFFF_FFF9, 64'h1234_0000_0000_0002,
                           2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                           64'h0000_0000_FFFF_FFFF, '1, 2, 0, 0));
`ifdef DIV_FRONTEND_ZERO_SHORTCUT_EN
        vecs.push_back(mkv(2, 64'h0000_0001_8000_0005, 64'd0, 2'd3, 1'b1,
                           64'hFFFF_FFFF_8000_0005, 64'd0, 64'd0,
                           64'hFFFF_FFFF_8000_0005, 0, 1, 0));
`endif

        foreach (vecs[k]) begin
            issue_to_result(vecs[k]);
            finish_wb();
        end

        // Writeback handshake alongside a new request: no same-cycle accept.
        issue_to_result(vecs[0]);
        id = 3'd6; op_a = 64'd9; op_b = 64'd2; opcode = 2'd0; word = 1'b0;
        req_vld = 1'b1;
        wb_rdy  = 1'b1;
        #1;
        chk("turn_req_rdy", W'(req_rdy), 0);
        chk("turn_wb_vld", W'(wb_vld), 1);
        @(negedge clk);
        wb_rdy = 1'b0;
        #1;
        chk("turn_wb_vld_after", W'(wb_vld), 0);
        chk("turn_req_rdy_after", W'(req_rdy), 1);
        issue_to_result(mkv(6, 64'd9, 64'd2, 2'd0, 1'b0, 64'd9, 64'd2,
                            64'd4, 64'd4, 0, 0, 0));
        finish_wb();

        // Flush while waiting on the divider.
        accept_only(3'd5);
        @(negedge clk); #1;
        chk("fw_in_wait", W'(div_out_rdy), 1);
        flush = 1'b1;
        #1;
        chk("fw_div_flush", W'(div_flush), 1);
        chk("fw_out_rdy", W'(div_out_rdy), 0);
        chk("fw_req_rdy", W'(req_rdy), 0);
        @(negedge clk);
        flush = 1'b0;
        div_out_vld = 1'b1;
        div_id_in = 3'd5;
        div_res = 64'd10;
        #1;
        chk("fw_req_rdy_next", W'(req_rdy), 1);
        chk("fw_out_rdy_next", W'(div_out_rdy), 0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("fw_no_wb_vld", W'(wb_vld), 0);
        end
        div_out_vld = 1'b0;

        // Flush while issuing.
        accept_only(3'd2);
        chk("fi_div_vld_pre", W'(div_vld), 1);
        flush = 1'b1;
        #1;
        chk("fi_div_vld", W'(div_vld), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fi_req_rdy", W'(req_rdy), 1);

        // Flush while presenting a result.
        issue_to_result(vecs[1]);
        flush = 1'b1;
        #1;
        chk("fr_wb_vld", W'(wb_vld), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fr_wb_vld_next", W'(wb_vld), 0);
        chk("fr_req_rdy_next", W'(req_rdy), 1);

        // A request in a flush cycle is dropped.
        req_vld = 1'b1;
        flush = 1'b1;
        #1;
        chk("fq_req_rdy", W'(req_rdy), 0);
        @(negedge clk);
        req_vld = 1'b0;
        flush = 1'b0;
        #1;
        chk("fq_still_idle", W'(req_rdy), 1);
        @(negedge clk); #1;
        chk("fq_no_issue", W'(div_vld), 0);

        // Reset in the middle of an operation.
        accept_only(3'd7);
        @(negedge clk);
        rst_n = 1'b0;
        div_out_vld = 1'b1;
        div_id_in = 3'd7;
        div_res = 64'd3;
        #1;
        chk("mr_out_rdy", W'(div_out_rdy), 0);
        @(negedge clk); #1;
        chk("mr_div_op_a", div_op_a, 0);
        chk("mr_wb_res", wb_res, 0);
        rst_n = 1'b1;
        div_out_vld = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("mr_no_wb_vld", W'(wb_vld), 0);
        end
        chk("mr_req_rdy", W'(req_rdy), 1);

        for (int r = 0; r < 40; r++) begin
            issue_to_result(mk_random());
            finish_wb();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
